riscv_tag_exc_unit: RTL and testbench
=====================================

Name: riscv_tag_exc_unit

Overview:
- Downstream consumer of the DIFT tag-check units: load check, store check and jump/branch check.
- Arbitrates their single-cycle exception pulses and latches cause, faulting PC and address.
- Presents one registered request to the core controller and holds it until acknowledged.
- Sits beside the WB stage and stalls the pipeline while a tag exception is pending; also keeps a saturating exception counter and a sticky overflow flag, both readable via CSR.

Parameters:
- CNT_W, 8, width of saturating tag-exception counter.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- load_exc_i  input  1  exception pulse from load tag check
- store_exc_i  input  1  exception pulse from store tag check
- jump_exc_i  input  1  exception pulse from jump/branch tag check
- pc_wb_i  input  32  PC of instruction in WB
- addr_wb_i  input  32  data/target address associated with WB instruction
- exc_ack_i  input  1  controller has taken the tag exception
- clear_i  input  1  CSR write: clear counter and overflow flag
- exc_req_o  output  1  registered tag-exception request to controller
- exc_cause_o  output  2  latched cause code
- exc_pc_o  output  32  latched faulting PC
- exc_addr_o  output  32  latched faulting address
- stall_o  output  1  freeze pipeline while exception pending
- exc_cnt_o  output  CNT_W  number of captured exceptions, saturating
- exc_ovf_o  output  1  sticky: exception arrived while one was pending

Behaviour:
- Clock and reset: clk, rst_n; one clock domain; asynchronous active-low reset.
- Reset values: all outputs 0, state IDLE.
- States:
  - IDLE: when any *_exc_i is high, capture and go to PEND. exc_req_o is high from the next cycle; latency is exactly 1 cycle.
  - PEND: exc_req_o=1 and stall_o=1, with stall_o decoded from state. Cause, PC and address are held stable.
  - On exc_ack_i: return to IDLE, dropping exc_req_o the following cycle.
- Priority when several inputs are high in one cycle: load > store > jump. Only one cause is captured; the losers are discarded, and exc_ovf_o is not set.
- Cause encoding: 2'b01 load, 2'b10 store, 2'b11 jump; 2'b00 means none, which is the reset value.
- Exception in PEND without exc_ack_i: not captured; exc_ovf_o set (sticky).
- Exception in PEND together with exc_ack_i:
  - The new exception is captured (new cause, PC and address); state stays PEND.
  - exc_req_o stays high continuously, and the controller sees a new request on the next cycle.
  - exc_ovf_o is not set.
- Counter: exc_cnt_o increments by 1 per captured exception and saturates at 2^CNT_W-1, with no wrap.
- clear_i:
  - Zeroes exc_cnt_o and exc_ovf_o next cycle; it does not affect state, request or latched fields.
  - If a capture occurs in the same cycle, clear wins over the increment: counter = 0. Capture still happens.
  - clear_i and an overflow event in the same cycle: exc_ovf_o = 0.
- exc_ack_i in IDLE is ignored.
- Reset mid-PEND: request, stall and all latched fields clear immediately (async).

Optional Feature:
- Macro: DIFT_EXC_ADDR_EN.
- Defined: addr_wb_i is latched into exc_addr_o on capture.
- Undefined: the address register is not instantiated, exc_addr_o is tied to 32'h0 and addr_wb_i is unused. All other behaviour is identical.

Decomposition:
- riscv_defines package:
  - TAG_EXC_NONE/LOAD/STORE/JUMP 2-bit cause constants.
  - tag_exc_state_e enum {IDLE, PEND}.
- Sub-module riscv_tag_exc_arb: combinational priority encoder giving {any_exc, cause[1:0]} from the three pulses.
- The FSM, latches and counter stay in the top module.

Test Plan:
- Reset, then load_exc_i=1 for 1 cycle with pc_wb_i=0x100, addr_wb_i=0x2000 -> next cycle exc_req_o=1, cause=01, exc_pc_o=0x100, exc_addr_o=0x2000, stall_o=1, exc_cnt_o=1.
- load, store and jump all pulsed in the same cycle -> cause=01, exc_cnt_o=1, exc_ovf_o=0.
- In PEND, store_exc_i pulsed without ack -> cause stays 01, exc_ovf_o=1, exc_cnt_o unchanged. Then exc_ack_i -> exc_req_o=0 and stall_o=0 the next cycle.
- In PEND (PC 0x100), exc_ack_i and jump_exc_i with pc_wb_i=0x200 in the same cycle -> exc_req_o stays 1, cause=11, exc_pc_o=0x200, exc_cnt_o increments, exc_ovf_o=0.
- With CNT_W=2: 5 capture/ack cycles -> exc_cnt_o saturates at 3. clear_i together with a capture -> exc_cnt_o=0 and the new cause is latched.
- Assert rst_n=0 mid-PEND, asynchronously off the clock edge -> exc_req_o, stall_o and cause drop immediately. Rebuild without DIFT_EXC_ADDR_EN -> exc_addr_o=0 after capture.

Source files
------------

// File: rtl/riscv_tag_exc_unit_pkg.sv
// riscv_tag_exc_unit_pkg: shared cause codes and FSM state type for the DIFT tag-exception unit
package riscv_tag_exc_unit_pkg;
  localparam logic [1:0] TAG_EXC_NONE  = 2'b00;
  localparam logic [1:0] TAG_EXC_LOAD  = 2'b01;
  localparam logic [1:0] TAG_EXC_STORE = 2'b10;
  localparam logic [1:0] TAG_EXC_JUMP  = 2'b11;
  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} tag_exc_state_e;
endpackage

// File: rtl/riscv_tag_exc_arb.sv
// riscv_tag_exc_arb: fixed-priority (load > store > jump) encoder for the tag-check exception pulses
module riscv_tag_exc_arb
  import riscv_tag_exc_unit_pkg::*;
(
  input  logic       load_exc_i,
  input  logic       store_exc_i,
  input  logic       jump_exc_i,
  output logic       any_exc_o,
  output logic [1:0] cause_o
);
  assign any_exc_o = load_exc_i | store_exc_i | jump_exc_i;
  assign cause_o   = load_exc_i  ? TAG_EXC_LOAD  :
                     store_exc_i ? TAG_EXC_STORE :
                     jump_exc_i  ? TAG_EXC_JUMP  : TAG_EXC_NONE;
endmodule

// File: rtl/riscv_tag_exc_unit.sv
// riscv_tag_exc_unit: captures DIFT tag exceptions, requests/stalls until acked, counts them; DIFT_EXC_ADDR_EN latches the faulting address
module riscv_tag_exc_unit
  import riscv_tag_exc_unit_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_exc_i,
  input  logic             store_exc_i,
  input  logic             jump_exc_i,
  input  logic [31:0]      pc_wb_i,
  input  logic [31:0]      addr_wb_i,
  input  logic             exc_ack_i,
  input  logic             clear_i,
  output logic             exc_req_o,
  output logic [1:0]       exc_cause_o,
  output logic [31:0]      exc_pc_o,
  output logic [31:0]      exc_addr_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] exc_cnt_o,
  output logic             exc_ovf_o
);
  tag_exc_state_e   state_q, state_d;
  logic [1:0]       cause_q, arb_cause;
  logic [31:0]      pc_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d, any_exc, capture, ovf_evt;

  riscv_tag_exc_arb u_arb (
    .load_exc_i (load_exc_i),
    .store_exc_i(store_exc_i),
    .jump_exc_i (jump_exc_i),
    .any_exc_o  (any_exc),
    .cause_o    (arb_cause)
  );

  // an ack frees the slot in the same cycle, so a coincident exception is taken instead of overflowing
  always_comb begin
    capture = any_exc & (state_q == IDLE | exc_ack_i);
    ovf_evt = any_exc & state_q == PEND & ~exc_ack_i;
    state_d = capture ? PEND : (exc_ack_i ? IDLE : state_q);
    cnt_d   = clear_i ? '0 : (capture && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    ovf_d   = ~clear_i & (ovf_q | ovf_evt);
  end

  // FSM, latched cause/PC, saturating counter and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cause_q <= TAG_EXC_NONE;
      pc_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      if (capture) begin
        cause_q <= arb_cause;
        pc_q    <= pc_wb_i;
      end
    end
  end

`ifdef DIFT_EXC_ADDR_EN
  logic [31:0] addr_q;
  // faulting address latched alongside the PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_q <= '0;
    else if (capture) addr_q <= addr_wb_i;
  end
  assign exc_addr_o = addr_q;
`else
  logic unused_addr;
  assign unused_addr = ^addr_wb_i;
  assign exc_addr_o  = 32'h0;
`endif

  assign exc_req_o   = state_q == PEND;
  assign stall_o     = state_q == PEND;
  assign exc_cause_o = cause_q;
  assign exc_pc_o    = pc_q;
  assign exc_cnt_o   = cnt_q;
  assign exc_ovf_o   = ovf_q;
endmodule

// File: tb/tb_riscv_tag_exc_unit.sv
// tb_riscv_tag_exc_unit: directed plus randomized checks of riscv_tag_exc_unit against a behavioural model
module tb_riscv_tag_exc_unit;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic load_exc_i = 0, store_exc_i = 0, jump_exc_i = 0, exc_ack_i = 0, clear_i = 0;
  logic [31:0] pc_wb_i = 0, addr_wb_i = 0;
  logic exc_req_o, stall_o, exc_ovf_o;
  logic [1:0] exc_cause_o;
  logic [31:0] exc_pc_o, exc_addr_o;
  logic [CNT_W-1:0] exc_cnt_o;

  int n_chk = 0, n_err = 0;
  bit m_pend;
  int m_cause, m_cnt;
  bit m_ovf;
  logic [31:0] m_pc, m_addr;

  riscv_tag_exc_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_exc_i(load_exc_i), .store_exc_i(store_exc_i), .jump_exc_i(jump_exc_i),
    .pc_wb_i(pc_wb_i), .addr_wb_i(addr_wb_i),
    .exc_ack_i(exc_ack_i), .clear_i(clear_i),
    .exc_req_o(exc_req_o), .exc_cause_o(exc_cause_o), .exc_pc_o(exc_pc_o),
    .exc_addr_o(exc_addr_o), .stall_o(stall_o), .exc_cnt_o(exc_cnt_o), .exc_ovf_o(exc_ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_cause = 0; m_cnt = 0; m_ovf = 0; m_pc = 0; m_addr = 0;
  endtask

  task automatic check_all();
    chk("req", 32'(exc_req_o), 32'(m_pend));
    chk("stall", 32'(stall_o), 32'(m_pend));
    chk("cause", 32'(exc_cause_o), 32'(m_cause));
    chk("pc", exc_pc_o, m_pc);
`ifdef DIFT_EXC_ADDR_EN
    chk("addr", exc_addr_o, m_addr);
`else
    chk("addr", exc_addr_o, 32'h0);
`endif
    chk("cnt", 32'(exc_cnt_o), 32'(m_cnt));
    chk("ovf", 32'(exc_ovf_o), 32'(m_ovf));
  endtask

  // one clock of stimulus; the model follows the rules: winner by priority, taken when free or acked
  task automatic cyc(input bit l, input bit s, input bit j, input bit ack, input bit clr,
                     input logic [31:0] pc, input logic [31:0] addr);
    bit any, was_pend;
    int c;
    load_exc_i = l; store_exc_i = s; jump_exc_i = j; exc_ack_i = ack; clear_i = clr;
    pc_wb_i = pc; addr_wb_i = addr;
    @(posedge clk);
    any = l || s || j;
    c = l ? 1 : s ? 2 : j ? 3 : 0;
    was_pend = m_pend;
    if (any && (!was_pend || ack)) begin
      m_pend = 1; m_cause = c; m_pc = pc; m_addr = addr;
      if (m_cnt < CNT_MAX) m_cnt++;
    end else if (was_pend && ack) m_pend = 0;
    if (any && was_pend && !ack) m_ovf = 1;
    if (clr) begin m_cnt = 0; m_ovf = 0; end
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    @(negedge clk) rst_n = 1'b1;
    cyc(1, 0, 0, 0, 0, 32'h100, 32'h2000);
    cyc(0, 1, 0, 0, 0, 32'h104, 32'h2004);
    cyc(0, 0, 0, 1, 0, 32'h108, 32'h0);
    cyc(0, 0, 0, 0, 1, 32'h0, 32'h0);
    cyc(1, 1, 1, 0, 0, 32'h100, 32'h3000);
    cyc(0, 1, 0, 0, 0, 32'h104, 32'h3004);
    cyc(0, 0, 1, 1, 0, 32'h200, 32'h4000);
    cyc(0, 0, 0, 1, 1, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 0, 0, 32'h300 + 32'(i), 32'h5000 + 32'(i));
      cyc(0, 0, 0, 1, 0, 32'h0, 32'h0);
    end
    cyc(0, 0, 1, 0, 1, 32'h400, 32'h6000);
    cyc(1, 0, 0, 1, 1, 32'h404, 32'h6004);
    cyc(0, 0, 0, 1, 0, 32'h0, 32'h0);
    cyc(0, 0, 0, 1, 0, 32'h0, 32'h0);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
          $urandom_range(2) == 0, $urandom_range(9) == 0, $urandom, $urandom);
    cyc(0, 0, 1, 0, 0, 32'h500, 32'h7000);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_req", 32'(exc_req_o), 32'h0);
    chk("async_stall", 32'(stall_o), 32'h0);
    chk("async_cause", 32'(exc_cause_o), 32'h0);
    chk("async_pc", exc_pc_o, 32'h0);
    chk("async_cnt", 32'(exc_cnt_o), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    cyc(0, 1, 0, 0, 0, 32'h600, 32'h8000);
    cyc(0, 0, 0, 1, 0, 32'h0, 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
